// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types and helpers for the lsu_port load/store initiator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE0  = 3'd1,
    ST_ISSUE1  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_RESP    = 3'd4
  } state_e;

  function automatic logic [2:0] size_bytes(input size_e s);
    case (s)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
// Module   : lsu_align
// Brief    : Byte-lane alignment for stores and shift/extend for loads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] st_wdata_i,
  input  logic [1:0]  st_offset_i,
  input  logic [1:0]  st_size_i,
  output logic [63:0] st_lanes_o,
  output logic [7:0]  st_mask_o,
  input  logic [63:0] ld_rdata_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  output logic [31:0] ld_result_o
);

  logic [7:0]  st_base;
  logic [31:0] ld_shifted;

  always_comb begin
    st_base = 8'h0F;
    case (st_size_i)
      SIZE_B:  st_base = 8'h01;
      SIZE_H:  st_base = 8'h03;
      default: st_base = 8'h0F;
    endcase
    st_lanes_o = {32'd0, st_wdata_i} << {st_offset_i, 3'b000};
    st_mask_o  = st_base << st_offset_i;
  end

  always_comb begin
    ld_shifted  = 32'(ld_rdata_i >> {ld_offset_i, 3'b000});
    ld_result_o = ld_shifted;
    case (ld_size_i)
      SIZE_B:  ld_result_o = ld_unsigned_i ? {24'd0, ld_shifted[7:0]}
                                           : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      SIZE_H:  ld_result_o = ld_unsigned_i ? {16'd0, ld_shifted[15:0]}
                                           : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_result_o = ld_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_port.sv
// ============================================================================
// Module   : lsu_port
// Brief    : CPU load/store initiator driving one byte-enabled RAM port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_port
  import lsu_pkg::*;
#(
  parameter int unsigned DEPTH          = 1024,
  parameter bit          MISALIGN_SPLIT = 1'b1,
  localparam int         AW             = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_error,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_e        state_q, state_d;

  logic          write_q;
  logic          unsigned_q;
  logic [1:0]    size_q;
  logic [1:0]    offset_q;
  logic          cross_q;
  logic [7:0]    mask_q;
  logic [31:0]   wdata_hi_q;
  logic [31:0]   beat0_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_error_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;

  logic          accept;
  logic [1:0]    req_offset;
  logic [2:0]    req_nbytes;
  logic [3:0]    req_end;
  logic          req_cross;
  logic          req_err;
  logic [AW-1:0] req_word;
  logic [AW-1:0] next_word;
  logic [63:0]   st_lanes;
  logic [7:0]    st_mask;
  logic [63:0]   ld_rdata64;
  logic [31:0]   ld_result;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];

  // Request decode on the live inputs; only meaningful in the accept cycle.
  assign accept     = req_valid && (state_q == ST_IDLE);
  assign req_offset = req_addr[1:0];
  assign req_nbytes = size_bytes((req_size == 2'd3) ? SIZE_W : size_e'(req_size));
  assign req_end    = {2'b00, req_offset} + {1'b0, req_nbytes};
  assign req_cross  = (req_end > 4'd4);
  assign req_err    = (req_size == 2'd3) || (req_cross && !MISALIGN_SPLIT);
  assign req_word   = req_addr[AW+1:2];
  assign next_word  = (mem_addr_q == AW'(DEPTH - 1)) ? '0 : mem_addr_q + AW'(1);

  // Split loads: low beat was latched in ISSUE1, high beat is on mem_rdata now.
  assign ld_rdata64 = cross_q ? {mem_rdata, beat0_q} : {32'd0, mem_rdata};

  lsu_align u_align (
    .st_wdata_i    (req_wdata),
    .st_offset_i   (req_offset),
    .st_size_i     (req_size),
    .st_lanes_o    (st_lanes),
    .st_mask_o     (st_mask),
    .ld_rdata_i    (ld_rdata64),
    .ld_offset_i   (offset_q),
    .ld_size_i     (size_q),
    .ld_unsigned_i (unsigned_q),
    .ld_result_o   (ld_result)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept) state_d = req_err ? ST_RESP : ST_ISSUE0;
      ST_ISSUE0:  state_d = cross_q ? ST_ISSUE1 : (write_q ? ST_RESP : ST_CAPTURE);
      ST_ISSUE1:  state_d = write_q ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESP;
      ST_RESP:    if (rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    mem_we    = 4'd0;
    if (write_q && (state_q == ST_ISSUE0)) mem_we = mask_q[3:0];
    if (write_q && (state_q == ST_ISSUE1)) mem_we = mask_q[7:4];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      write_q     <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= 2'd0;
      offset_q    <= 2'd0;
      cross_q     <= 1'b0;
      mask_q      <= 8'd0;
      wdata_hi_q  <= 32'd0;
      beat0_q     <= 32'd0;
      rsp_rdata_q <= 32'd0;
      rsp_error_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      if (accept) begin
        write_q     <= req_write;
        unsigned_q  <= req_unsigned;
        size_q      <= req_size;
        offset_q    <= req_offset;
        cross_q     <= req_cross;
        mask_q      <= st_mask;
        wdata_hi_q  <= st_lanes[63:32];
        rsp_rdata_q <= 32'd0;
        rsp_error_q <= req_err;
        if (!req_err) begin
          mem_addr_q  <= req_word;
          mem_wdata_q <= st_lanes[31:0];
        end
      end
      if ((state_q == ST_ISSUE0) && cross_q) begin
        mem_addr_q  <= next_word;
        mem_wdata_q <= wdata_hi_q;
      end
      if (state_q == ST_ISSUE1) begin
        beat0_q <= mem_rdata;
      end
      if (state_q == ST_CAPTURE) begin
        rsp_rdata_q <= ld_result;
      end
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire
